approx_add_pipe: RTL

Parametrised, pipelined approximate signed adder, the next generation of the team's fixed 8-bit approximate adders. Low-order result bits are produced by a cheap OR approximation, with a run-time selectable approximation depth and a carry predicted from the top approximated bit; the upper bits are exact. The block sits between the CNN accelerator's operand FIFO and its accumulator and uses valid/ready handshakes on both sides. An optional error monitor compares every result against the exact sum.

---
 rtl/approx_add_pipe.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/approx_add_pipe.sv
// Two-stage pipelined approximate signed adder: low k bits OR-approximated, upper bits exact
// with a carry predicted from bit k-1. Optional error monitor enabled by APPROX_ADD_ERR_MON_EN.
module approx_add_pipe #(
  parameter int W     = 8,
  parameter int K_MAX = 4,
  parameter int KW    = $clog2(K_MAX + 1),
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [KW-1:0]    k_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       sum,
  input  logic             err_clr,
  output logic [ACC_W-1:0] err_cnt,
  output logic [ACC_W-1:0] err_abs_sum,
  output logic [W+1:0]     err_abs_max
);

  logic          s1_valid;
  logic [W-1:0]  s1_a;
  logic [W-1:0]  s1_b;
  logic [KW-1:0] s1_k;
  logic          s2_valid;
  logic [W:0]    s2_sum;

  logic          s2_load;
  logic          in_fire;
  logic          emit;
  logic [KW-1:0] k_clamp;

  // in_ready depends only on pipeline state and out_ready, never on in_valid
  assign s2_load   = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_load;
  assign in_fire   = in_valid && in_ready;
  assign emit      = s2_valid && out_ready;
  assign k_clamp   = (k_sel > KW'(K_MAX)) ? KW'(K_MAX) : k_sel;
  assign out_valid = s2_valid;
  assign sum       = s2_sum;

  logic [W:0]        a_x;
  logic [W:0]        b_x;
  logic [W:0]        low_mask;
  logic [W:0]        carry_mask;
  logic              c_in;
  logic signed [W:0] a_hi;
  logic signed [W:0] b_hi;
  logic [W:0]        hi_sum;
  logic [W:0]        approx_sum;

  always_comb begin
    a_x        = {s1_a[W-1], s1_a};
    b_x        = {s1_b[W-1], s1_b};
    low_mask   = ~({(W+1){1'b1}} << s1_k);
    // single bit at position k-1, empty when k = 0
    carry_mask = low_mask ^ (low_mask >> 1);
    c_in       = |(a_x & b_x & carry_mask);
    a_hi       = $signed(a_x) >>> s1_k;
    b_hi       = $signed(b_x) >>> s1_k;
    hi_sum     = a_hi + b_hi + {{W{1'b0}}, c_in};
    approx_sum = (hi_sum << s1_k) | ((a_x | b_x) & low_mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_k     <= '0;
      s2_valid <= 1'b0;
      s2_sum   <= '0;
    end else begin
      if (in_fire) begin
        s1_a <= a;
        s1_b <= b;
        s1_k <= k_clamp;
      end
      if (in_fire) begin
        s1_valid <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_sum <= approx_sum;
        end
      end
    end
  end

`ifdef APPROX_ADD_ERR_MON_EN
  logic [W:0]          s2_exact;
  logic [W+1:0]        err_e;
  logic [W+1:0]        err_mag;
  logic [ACC_W:0]      abs_sum_ext;

  always_comb begin
    err_e       = {s2_sum[W], s2_sum} - {s2_exact[W], s2_exact};
    err_mag     = err_e[W+1] ? (~err_e + 1'b1) : err_e;
    abs_sum_ext = {1'b0, err_abs_sum} + (ACC_W+1)'(err_mag);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_exact    <= '0;
      err_cnt     <= '0;
      err_abs_sum <= '0;
      err_abs_max <= '0;
    end else begin
      if (s2_load && s1_valid) begin
        s2_exact <= a_x + b_x;
      end
      if (err_clr) begin
        err_cnt     <= '0;
        err_abs_sum <= '0;
        err_abs_max <= '0;
      end else if (emit) begin
        if ((err_e != '0) && (err_cnt != '1)) begin
          err_cnt <= err_cnt + 1'b1;
        end
        err_abs_sum <= abs_sum_ext[ACC_W] ? '1 : abs_sum_ext[ACC_W-1:0];
        if (err_mag > err_abs_max) begin
          err_abs_max <= err_mag;
        end
      end
    end
  end
`else
  logic unused_mon;
  assign unused_mon  = err_clr ^ emit;
  assign err_cnt     = '0;
  assign err_abs_sum = '0;
  assign err_abs_max = '0;
`endif

endmodule
